// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one single-precision multiplier among NREQ valid/ready
// requesters; operands and results are registered, completions are counted.

module Multiplication (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic        o_exception,
    output logic        o_overflow,
    output logic        o_underflow,
    output logic [31:0] o_result
);
    logic        w_sign;
    logic        w_norm;
    logic        w_zero;
    logic [23:0] w_man_a;
    logic [23:0] w_man_b;
    logic [47:0] w_prod;
    logic [8:0]  w_exp_sum;
    logic [8:0]  w_exp;
    logic [22:0] w_man;

    assign w_sign      = i_a[31] ^ i_b[31];
    assign o_exception = (&i_a[30:23]) | (&i_b[30:23]);
    assign w_man_a     = {|i_a[30:23], i_a[22:0]};
    assign w_man_b     = {|i_b[30:23], i_b[22:0]};
    assign w_prod      = {24'd0, w_man_a} * {24'd0, w_man_b};
    assign w_norm      = w_prod[47];
    // Mantissa is truncated, no rounding.
    assign w_man       = w_norm ? w_prod[46:24] : w_prod[45:23];
    assign w_zero      = ~|w_prod;
    assign w_exp_sum   = {1'b0, i_a[30:23]} + {1'b0, i_b[30:23]};
    assign w_exp       = w_exp_sum - 9'd127 + {8'd0, w_norm};
    assign o_overflow  = w_exp[8] & ~w_exp[7] & ~w_zero;
    assign o_underflow = w_exp[8] &  w_exp[7] & ~w_zero;

    always_comb begin
        o_result = {w_sign, w_exp[7:0], w_man};
        if (o_exception) begin
            o_result = 32'd0;
        end else if (w_zero || o_underflow) begin
            o_result = {w_sign, 31'd0};
        end else if (o_overflow) begin
            o_result = {w_sign, 8'hFF, 23'd0};
        end
    end
endmodule

// state  | meaning
// S_IDLE | waiting for a request; grant searched from r_ptr upward
// S_CALC | multiplier evaluating r_a/r_b; result captured at end of cycle
// S_RESP | response held on rsp_* until i_rsp_ready
module fp_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int CNTW = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req_valid,
    input  logic [32*NREQ-1:0]   i_req_a,
    input  logic [32*NREQ-1:0]   i_req_b,
    output logic [NREQ-1:0]      o_req_ready,
    output logic                 o_rsp_valid,
    output logic [NREQ-1:0]      o_rsp_id,
    input  logic                 i_rsp_ready,
    output logic [31:0]          o_rsp_result,
    output logic                 o_rsp_exception,
    output logic                 o_rsp_overflow,
    output logic                 o_rsp_underflow,
    output logic                 o_busy,
    output logic [CNTW-1:0]      o_op_count
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_gidx;
    logic [NREQ-1:0] w_grant;
    logic            w_found;
    logic [31:0]     w_sel_a;
    logic [31:0]     w_sel_b;
    logic            w_accept;
    logic            w_rsp_done;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [NREQ-1:0] r_id;
    logic            r_rsp_valid;
    logic [NREQ-1:0] r_rsp_id;
    logic [31:0]     r_rsp_result;
    logic            r_rsp_exception;
    logic            r_rsp_overflow;
    logic            r_rsp_underflow;
    logic [CNTW-1:0] r_op_count;
    logic [31:0]     w_mul_result;
    logic            w_mul_exception;
    logic            w_mul_overflow;
    logic            w_mul_underflow;

    Multiplication u_mul (
        .i_a         (r_a),
        .i_b         (r_b),
        .o_exception (w_mul_exception),
        .o_overflow  (w_mul_overflow),
        .o_underflow (w_mul_underflow),
        .o_result    (w_mul_result)
    );

    // Two passes: indices at or above r_ptr first, then the wrapped-around ones.
    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req_valid[i] && (i >= int'(r_ptr))) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_gidx     = PW'(i);
                w_sel_a    = i_req_a[32*i +: 32];
                w_sel_b    = i_req_b[32*i +: 32];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!w_found && i_req_valid[i]) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
                w_gidx     = PW'(i);
                w_sel_a    = i_req_a[32*i +: 32];
                w_sel_b    = i_req_b[32*i +: 32];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        o_req_ready = '0;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Grant is masked while reset is held so every output reads zero.
                o_req_ready = i_reset ? '0 : w_grant;
                if (w_found) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_CALC;
                end
            end
            S_CALC: begin
                w_state_nx = S_RESP;
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_rsp_done = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr           <= '0;
            r_a             <= '0;
            r_b             <= '0;
            r_id            <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_id        <= '0;
            r_rsp_result    <= '0;
            r_rsp_exception <= 1'b0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_underflow <= 1'b0;
            r_op_count      <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_id  <= w_grant;
                r_ptr <= (w_gidx == PW'(NREQ - 1)) ? '0 : w_gidx + PW'(1);
            end
            if (r_state == S_CALC) begin
                r_rsp_valid     <= 1'b1;
                r_rsp_id        <= r_id;
                r_rsp_result    <= w_mul_result;
                r_rsp_exception <= w_mul_exception;
                r_rsp_overflow  <= w_mul_overflow;
                r_rsp_underflow <= w_mul_underflow;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_op_count  <= r_op_count + CNTW'(1);
            end
        end
    end

    assign o_busy          = (r_state != S_IDLE);
    assign o_rsp_valid     = r_rsp_valid;
    assign o_rsp_id        = r_rsp_id;
    assign o_rsp_result    = r_rsp_result;
    assign o_rsp_exception = r_rsp_exception;
    assign o_rsp_overflow  = r_rsp_overflow;
    assign o_rsp_underflow = r_rsp_underflow;
    assign o_op_count      = r_op_count;
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: directed scenarios plus random traffic against a
// transaction-level arbitration model and a standalone reference multiplier.

module tb_fp_mul_arbiter;
    localparam int NREQ = 4;
    localparam int CNTW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                r_reset     = 1'b1;
    logic [NREQ-1:0]     r_valid     = '0;
    logic [32*NREQ-1:0]  r_a_bus     = '0;
    logic [32*NREQ-1:0]  r_b_bus     = '0;
    logic                r_rsp_ready = 1'b0;
    logic                r_hold      = 1'b0;

    wire [NREQ-1:0] w_req_ready;
    wire            w_rsp_valid;
    wire [NREQ-1:0] w_rsp_id;
    wire [31:0]     w_rsp_result;
    wire            w_rsp_exception;
    wire            w_rsp_overflow;
    wire            w_rsp_underflow;
    wire            w_busy;
    wire [CNTW-1:0] w_op_count;

    fp_mul_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .i_clk           (clk),
        .i_reset         (r_reset),
        .i_req_valid     (r_valid),
        .i_req_a         (r_a_bus),
        .i_req_b         (r_b_bus),
        .o_req_ready     (w_req_ready),
        .o_rsp_valid     (w_rsp_valid),
        .o_rsp_id        (w_rsp_id),
        .i_rsp_ready     (r_rsp_ready),
        .o_rsp_result    (w_rsp_result),
        .o_rsp_exception (w_rsp_exception),
        .o_rsp_overflow  (w_rsp_overflow),
        .o_rsp_underflow (w_rsp_underflow),
        .o_busy          (w_busy),
        .o_op_count      (w_op_count)
    );

    logic [31:0] ref_a = '0;
    logic [31:0] ref_b = '0;
    wire  [31:0] ref_res;
    wire         ref_exc;
    wire         ref_ovf;
    wire         ref_unf;

    Multiplication u_ref (
        .i_a         (ref_a),
        .i_b         (ref_b),
        .o_exception (ref_exc),
        .o_overflow  (ref_ovf),
        .o_underflow (ref_unf),
        .o_result    (ref_res)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: phase 0 idle, 1 computing, 2 response pending.
    int m_phase = 0;
    int m_ptr   = 0;
    int m_gid   = 0;
    int m_cnt   = 0;

    int              acc_id[$];
    int              acc_cyc[$];
    int              rsp_cyc[$];
    logic [31:0]     rsp_res[$];
    logic [2:0]      rsp_flg[$];
    logic [NREQ-1:0] rsp_idq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            if (r_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_state();
        int              g;
        logic [NREQ-1:0] exp_rdy;
        g       = pick();
        exp_rdy = (m_phase == 0 && g >= 0) ? (NREQ'(1) << g) : '0;
        chk("req_ready", 64'(w_req_ready), 64'(exp_rdy));
        chk("busy", 64'(w_busy), 64'(m_phase != 0));
        chk("rsp_valid", 64'(w_rsp_valid), 64'(m_phase == 2));
        chk("op_count", 64'(w_op_count), 64'(m_cnt));
        if (m_phase == 2) begin
            chk("rsp_id", 64'(w_rsp_id), 64'(NREQ'(1) << m_gid));
            chk("rsp_result", 64'(w_rsp_result), 64'(ref_res));
            chk("rsp_flags", 64'({w_rsp_exception, w_rsp_overflow, w_rsp_underflow}),
                64'({ref_exc, ref_ovf, ref_unf}));
        end
    endtask

    // One clock: observe handshakes before the edge, advance the model, check after.
    task automatic cycle();
        logic [NREQ-1:0] acc;
        int              g;
        #1;
        acc = w_req_ready & r_valid;
        if (acc != '0) begin
            acc_id.push_back(onehot_idx(acc));
            acc_cyc.push_back(cyc);
        end
        if (w_rsp_valid && r_rsp_ready) begin
            rsp_res.push_back(w_rsp_result);
            rsp_flg.push_back({w_rsp_exception, w_rsp_overflow, w_rsp_underflow});
            rsp_idq.push_back(w_rsp_id);
            rsp_cyc.push_back(cyc);
        end
        case (m_phase)
            0: begin
                g = pick();
                if (g >= 0) begin
                    m_gid   = g;
                    ref_a   = r_a_bus[32*g +: 32];
                    ref_b   = r_b_bus[32*g +: 32];
                    m_ptr   = (g + 1) % NREQ;
                    m_phase = 1;
                end
            end
            1: m_phase = 2;
            default: begin
                if (r_rsp_ready) begin
                    m_phase = 0;
                    m_cnt   = (m_cnt + 1) % (1 << CNTW);
                end
            end
        endcase
        cyc++;
        @(negedge clk);
        check_state();
        if (!r_hold) r_valid = r_valid & ~acc;
    endtask

    task automatic check_zero();
        chk("rst_req_ready", 64'(w_req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(w_rsp_valid), 64'(0));
        chk("rst_busy", 64'(w_busy), 64'(0));
        chk("rst_op_count", 64'(w_op_count), 64'(0));
        chk("rst_rsp_result", 64'(w_rsp_result), 64'(0));
        chk("rst_rsp_id", 64'(w_rsp_id), 64'(0));
        chk("rst_flags", 64'({w_rsp_exception, w_rsp_overflow, w_rsp_underflow}), 64'(0));
    endtask

    task automatic do_reset();
        #2;
        r_reset = 1'b1;
        #1;
        check_zero();
        m_phase = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        @(negedge clk);
        @(negedge clk);
        r_reset = 1'b0;
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b);
        int nr;
        int n;
        nr = rsp_res.size();
        r_a_bus[32*id +: 32] = a;
        r_b_bus[32*id +: 32] = b;
        r_valid[id] = 1'b1;
        n = 0;
        while (rsp_res.size() == nr && n < 40) begin
            cycle();
            n++;
        end
        chk("op_done", 64'(rsp_res.size() > nr), 64'(1));
        if (rsp_res.size() > nr && acc_id.size() > 0) begin
            chk("grant_id", 64'(acc_id[$]), 64'(id));
        end
    endtask

    initial begin
        int n;
        int na;
        int nr;

        @(negedge clk);
        check_zero();
        r_reset     = 1'b0;
        r_rsp_ready = 1'b1;

        // Single request from requester 0
        run_op(0, 32'h4234851F, 32'h427C851F);
        chk("single_result", 64'(rsp_res[$]), 64'(32'h453210E9));
        chk("single_id", 64'(rsp_idq[$]), 64'(4'b0001));
        chk("single_flags", 64'(rsp_flg[$]), 64'(0));
        chk("single_latency", 64'(rsp_cyc[$] - acc_cyc[$]), 64'(2));
        chk("single_count", 64'(w_op_count), 64'(1));

        // Identity and zero from requester 2
        run_op(2, 32'h414DD70A, 32'h3F800000);
        chk("ident_result", 64'(rsp_res[$]), 64'(32'h414DD70A));
        chk("ident_id", 64'(rsp_idq[$]), 64'(4'b0100));
        chk("ident_flags", 64'(rsp_flg[$]), 64'(0));
        run_op(2, 32'h414DD70A, 32'h00000000);
        chk("zero_result", 64'(rsp_res[$]), 64'(32'h00000000));
        chk("zero_id", 64'(rsp_idq[$]), 64'(4'b0100));
        chk("zero_flags", 64'(rsp_flg[$]), 64'(0));

        // Backpressure: response held while requester 1 waits
        r_rsp_ready = 1'b0;
        r_a_bus[31:0] = 32'h40400000;
        r_b_bus[31:0] = 32'h40000000;
        r_valid[0] = 1'b1;
        na = acc_id.size();
        n = 0;
        while (acc_id.size() == na && n < 20) begin
            cycle();
            n++;
        end
        cycle();
        r_a_bus[63:32] = 32'h3FC00000;
        r_b_bus[63:32] = 32'h3FC00000;
        r_valid[1] = 1'b1;
        repeat (5) cycle();
        chk("bp_busy", 64'(w_busy), 64'(1));
        chk("bp_req_ready", 64'(w_req_ready), 64'(0));
        chk("bp_rsp_valid", 64'(w_rsp_valid), 64'(1));
        chk("bp_result", 64'(w_rsp_result), 64'(32'h40C00000));
        r_rsp_ready = 1'b1;
        na = acc_id.size();
        n = 0;
        while (acc_id.size() == na && n < 20) begin
            cycle();
            n++;
        end
        chk("bp_accepted", 64'(acc_id.size() > na), 64'(1));
        if (acc_id.size() > na && rsp_cyc.size() > 0) begin
            chk("bp_grant_id", 64'(acc_id[$]), 64'(1));
            chk("bp_accept_cycle", 64'(acc_cyc[$] - rsp_cyc[$]), 64'(1));
        end
        nr = rsp_res.size();
        n = 0;
        while (rsp_res.size() == nr && n < 20) begin
            cycle();
            n++;
        end
        chk("bp_second_result", 64'(rsp_res[$]), 64'(32'h40100000));

        // Overflow pass-through
        run_op(3, 32'h7F000000, 32'h7F000000);
        chk("ovf_flag", 64'(rsp_flg[$][1]), 64'(1));
        chk("ovf_result", 64'(rsp_res[$]), 64'(ref_res));
        chk("ovf_exception", 64'(rsp_flg[$][2]), 64'(ref_exc));

        // Fairness: all four requesters held valid from reset
        for (int i = 0; i < NREQ; i++) begin
            r_a_bus[32*i +: 32] = 32'h45800000;
            r_b_bus[32*i +: 32] = 32'h45800000;
        end
        r_valid = '1;
        r_hold  = 1'b1;
        do_reset();
        na = acc_id.size();
        nr = rsp_res.size();
        n = 0;
        while (acc_id.size() < na + 5 && n < 40) begin
            cycle();
            n++;
        end
        r_hold  = 1'b0;
        r_valid = '0;
        repeat (4) cycle();
        chk("fair_accepts", 64'(acc_id.size() >= na + 5), 64'(1));
        if (acc_id.size() >= na + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("fair_order", 64'(acc_id[na + k]), 64'(k % NREQ));
                if (k > 0) chk("fair_spacing", 64'(acc_cyc[na + k] - acc_cyc[na + k - 1]), 64'(3));
            end
        end
        chk("fair_responses", 64'(rsp_res.size() >= nr + 5), 64'(1));
        if (rsp_res.size() >= nr + 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("fair_result", 64'(rsp_res[nr + k]), 64'(32'h4B800000));
            end
        end

        // Reset during CALC discards the operation and the pointer
        r_a_bus[63:32] = 32'h40000000;
        r_b_bus[63:32] = 32'h40000000;
        r_valid[1] = 1'b1;
        na = acc_id.size();
        n = 0;
        while (acc_id.size() == na && n < 20) begin
            cycle();
            n++;
        end
        chk("mid_calc_busy", 64'(w_busy), 64'(1));
        r_a_bus[31:0]   = 32'h40000000;
        r_b_bus[31:0]   = 32'h40400000;
        r_a_bus[127:96] = 32'h3F800000;
        r_b_bus[127:96] = 32'hC0000000;
        r_valid[0] = 1'b1;
        r_valid[3] = 1'b1;
        nr = rsp_res.size();
        do_reset();
        chk("mid_no_rsp", 64'(rsp_res.size()), 64'(nr));
        na = acc_id.size();
        n = 0;
        while (rsp_res.size() < nr + 2 && n < 40) begin
            cycle();
            n++;
        end
        chk("mid_accepts", 64'(acc_id.size()), 64'(na + 2));
        if (acc_id.size() >= na + 2) begin
            chk("mid_first", 64'(acc_id[na]), 64'(0));
            chk("mid_second", 64'(acc_id[na + 1]), 64'(3));
        end
        chk("mid_count", 64'(w_op_count), 64'(2));

        // Random traffic; counter wraps several times with CNTW=4
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!r_valid[i] && $urandom_range(0, 3) == 0) begin
                    r_a_bus[32*i +: 32] = $urandom;
                    r_b_bus[32*i +: 32] = $urandom;
                    r_valid[i] = 1'b1;
                end
            end
            r_rsp_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        r_valid     = '0;
        r_rsp_ready = 1'b1;
        repeat (6) cycle();
        chk("final_idle", 64'(w_busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational IEEE-754 single-precision `Multiplication` unit among `NREQ` requesters. Each requester gets a valid/ready request channel. Results return on one shared response channel, tagged one-hot with the owning requester. The block sits between the FP ALU's client logic (odometry math pipelines) and the multiplier: it registers the multiplier's inputs and outputs and keeps a completed-operation count.

## Interface
- `NREQ`, default 4, number of requesters (2..8).
- `CNTW`, default 16, width of the completed-operation counter.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_a`  in  32*NREQ  operand A; requester i uses bits [32i+31:32i].
- `req_b`  in  32*NREQ  operand B, same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot grant/accept; a transfer occurs when `req_valid[i]` and `req_ready[i]` are both high on a rising edge.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  NREQ  one-hot owner of the current response.
- `rsp_ready`  in  1  response accept.
- `rsp_result`  out  32  product from `Multiplication`.
- `rsp_exception`, `rsp_overflow`, `rsp_underflow`  out  1 each  status flags from `Multiplication`.
- `busy`  out  1  high in any state other than IDLE.
- `op_count`  out  CNTW  number of completed responses; wraps modulo 2^CNTW.

## Operation
- Instantiates one `Multiplication`. Its inputs come only from the internal operand registers `a_q` and `b_q`.
- The FSM has three states: IDLE, CALC, RESP.
- **IDLE**
  - The grant is the first `i` with `req_valid[i]` high, searching from pointer `ptr` upward modulo NREQ.
  - `req_ready[i] = (state==IDLE) & grant[i]`. This is combinational from `req_valid` and `ptr`.
  - On a transfer: capture `a_q`/`b_q` from the granted slice, set `id_q` to the grant, set `ptr` to (granted index + 1) mod NREQ, and go to CALC.
  - With no valid request, stay in IDLE and leave `ptr` unchanged.
- **CALC**
  - The multiplier evaluates `a_q`/`b_q`.
  - At the end of the cycle, register result and flags into `rsp_*`, and `id_q` into `rsp_id`.
  - Go to RESP.
- **RESP**
  - `rsp_valid` is high.
  - All `rsp_*` outputs are held stable until `rsp_ready` is sampled high.
  - When `rsp_ready` is high: increment `op_count` and go to IDLE.
- `req_ready` is all-zero outside IDLE. Requests from non-granted requesters wait and are never dropped; a requester must hold `req_valid` and its operands until accepted.
- Changes on `req_a`/`req_b` after acceptance have no effect on the in-flight operation.
- Results are passed through from `Multiplication` unmodified. This block does no rounding or special-case handling.
- Reset
  - Clears: state to IDLE, `ptr` to 0, `a_q`, `b_q`, `id_q`, `rsp_id`, `rsp_result` and all flags to 0, `rsp_valid` to 0, `busy` to 0, `op_count` to 0.
  - Reset asserted mid-operation (CALC or RESP) discards the operation: no response is issued and `op_count` is not incremented.

## Timing
- A request accepted at rising edge T produces `rsp_valid` high from T+2.
- The earliest next acceptance is the edge after the response handshake. With `rsp_ready` held high, the response handshake occurs at T+2 and the next acceptance at T+3: at most one operation per 3 cycles.
- `rsp_valid` is registered and never combinational from inputs.
- `req_ready` and `busy` reflect the current state in the same cycle.
- When several requests are valid in the same IDLE cycle, exactly one is granted, chosen by `ptr`.
- Simultaneous `rsp_ready` and a new `req_valid` in RESP: the response completes and the new request is considered in the following IDLE cycle.
- `op_count` wrap: a count of 2^CNTW−1 plus one completion reads 0, with no flag.
- `rsp_ready` high while not in RESP is ignored.

## Test plan
- **Single request**
  - Stimulus: requester 0 sends 0x4234851F × 0x427C851F with `rsp_ready`=1.
  - Required: `rsp_valid` 2 cycles after acceptance, `rsp_result`=0x453210E9, `rsp_id`=0001, all flags 0, `op_count`=1.
- **Identity and zero**
  - Stimulus: requester 2 sends 0x414DD70A × 0x3F800000, then 0x414DD70A × 0x00000000.
  - Required: results 0x414DD70A and 0x00000000, `rsp_id`=0100 for both, flags 0.
- **Fairness**
  - Stimulus: all four `req_valid` held high continuously from reset; operands are 4096.0 (0x45800000) squared.
  - Required: grant order 0,1,2,3,0; each result 0x4B800000; acceptances spaced exactly 3 cycles apart.
- **Backpressure**
  - Stimulus: hold `rsp_ready`=0 for 5 cycles in RESP while requester 1 asserts `req_valid`.
  - Required: `rsp_*` stable, `req_ready`=0000, `busy`=1; requester 1 is accepted on the first IDLE cycle after `rsp_ready`.
- **Overflow pass-through**
  - Stimulus: 0x7F000000 × 0x7F000000.
  - Required: `rsp_overflow`=1, and `rsp_result`/`rsp_exception` match a standalone `Multiplication` given the same operands.
- **Reset mid-operation**
  - Stimulus: assert `reset` during CALC.
  - Required: all outputs go to 0 immediately (asynchronous), and `ptr`=0. After release, the pending requests from requesters 0 and 3 are granted in order 0, then 3, and `op_count` counts only these completions.
